// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the multi-cycle processor's
//               fetch/load/store traffic. Single-ported DATA_WIDTH x DEPTH
//               array with WAIT_CYCLES programmable wait states and a
//               one-cycle mem_ready completion pulse.
// Ports       : clk, rst (async, active-high)
//               mem_read, mem_write, address, write_data  - request side
//               command    - registered read data, held until next read
//               mem_ready  - one-cycle completion pulse
//               busy       - request in flight (WAIT or DONE)
//               addr_err   - with mem_ready: out-of-range or illegal rd+wr
//               prot_err   - with mem_ready: rejected protected write
// Options     : define MEM_PROTECT_EN to block writes below PROTECT_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_WIDTH    = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8192,
  parameter int WAIT_CYCLES   = 2,
  parameter int PROTECT_LIMIT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] command,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  addr_err,
  output logic                  prot_err
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]          WAIT_LOAD_V = 4'(WAIT_LOAD);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PROT_EXT    = (ADDR_WIDTH+1)'(PROTECT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    run_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   command_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    addr_err_q;
  logic                    prot_err_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Operand selection: with zero wait states the access happens on the
  // acceptance edge itself, so the live request is used; otherwise the
  // copies latched at acceptance are used.
  logic                    accept_d;
  logic                    fire_d;
  logic                    op_rd;
  logic                    op_wr;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic [IDX_W-1:0]        op_idx;
  logic                    op_illegal;
  logic                    op_oor;
  logic                    op_prot;
  logic                    do_write;
  logic                    do_read;

  // run_q keeps an edge seen while rst is still high from accepting a
  // request (and, with zero wait states, from writing the array).
  assign accept_d   = run_q && (state_q == S_IDLE) && (mem_read || mem_write);
  assign fire_d     = ((WAIT_CYCLES == 0) && accept_d) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign op_rd      = (state_q == S_IDLE) ? mem_read   : rd_q;
  assign op_wr      = (state_q == S_IDLE) ? mem_write  : wr_q;
  assign op_addr    = (state_q == S_IDLE) ? address    : addr_q;
  assign op_wdata   = (state_q == S_IDLE) ? write_data : wdata_q;
  assign op_idx     = op_addr[IDX_W-1:0];
  assign op_illegal = op_rd && op_wr;
  assign op_oor     = {1'b0, op_addr} >= DEPTH_EXT;

`ifdef MEM_PROTECT_EN
  assign op_prot = op_wr && !op_rd && !op_oor && ({1'b0, op_addr} < PROT_EXT);
`else
  logic unused_prot;
  assign op_prot     = 1'b0;
  assign unused_prot = ^PROT_EXT;
`endif

  assign do_write = fire_d && op_wr && !op_rd && !op_oor && !op_prot;
  assign do_read  = fire_d && op_rd && !op_wr;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      run_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      command_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      prot_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            addr_q  <= address;
            wdata_q <= write_data;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LOAD_V;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Completion: outputs are registered on the edge that enters DONE.
      if (fire_d) begin
        ready_q    <= 1'b1;
        addr_err_q <= op_illegal || op_oor;
        prot_err_q <= op_prot;
        if (do_read) begin
          command_q <= op_oor ? '0 : mem_q[op_idx];
        end
      end
    end
  end

  assign command   = command_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign addr_err  = addr_err_q;
  assign prot_err  = prot_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Three instances:
//               A (WAIT=2, DEPTH=8192), B (WAIT=0, DEPTH=8192),
//               C (WAIT=2, DEPTH=4096, PROTECT_LIMIT=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd   [3];
  logic          wr   [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wd   [3];
  logic [DW-1:0] cmd  [3];
  logic          rdy  [3];
  logic          bsy  [3];
  logic          ae   [3];
  logic          pe   [3];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .address(addr[0]),
    .write_data(wd[0]), .command(cmd[0]), .mem_ready(rdy[0]), .busy(bsy[0]),
    .addr_err(ae[0]), .prot_err(pe[0]));

  mem_responder #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .address(addr[1]),
    .write_data(wd[1]), .command(cmd[1]), .mem_ready(rdy[1]), .busy(bsy[1]),
    .addr_err(ae[1]), .prot_err(pe[1]));

  mem_responder #(.WAIT_CYCLES(2), .DEPTH(4096), .PROTECT_LIMIT(0)) u_c (
    .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]), .address(addr[2]),
    .write_data(wd[2]), .command(cmd[2]), .mem_ready(rdy[2]), .busy(bsy[2]),
    .addr_err(ae[2]), .prot_err(pe[2]));

  typedef struct {
    int          inst;
    logic [DW-1:0] cmd;
    bit          ae;
    bit          pe;
  } exp_t;

  typedef struct {
    int            inst;
    bit            r;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] ecmd;
    bit            eae;
    bit            epe;
  } vec_t;

  exp_t sb [$];
  vec_t vt [15];
  int   total = 0;
  int   bad   = 0;

  function automatic int wc(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request, wait (bounded) for mem_ready, return what was seen.
  task automatic xfer(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] c,
                      output bit oae, output bit ope);
    int n;
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
    @(posedge clk); #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
    check($sformatf("busy_after_accept[%0d]", i), 32'(bsy[i]), 32'd1);
    n = 0;
    while (!rdy[i] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("ready_seen[%0d]", i), 32'(rdy[i]), 32'd1);
    check($sformatf("latency[%0d]", i), 32'(n), 32'(wc(i)));
    check($sformatf("busy_in_done[%0d]", i), 32'(bsy[i]), 32'd1);
    c = cmd[i]; oae = ae[i]; ope = pe[i];
    @(posedge clk); #1;
    check($sformatf("ready_one_cycle[%0d]", i), 32'(rdy[i]), 32'd0);
    check($sformatf("busy_back_idle[%0d]", i), 32'(bsy[i]), 32'd0);
    check($sformatf("addr_err_cleared[%0d]", i), 32'(ae[i]), 32'd0);
  endtask

  task automatic req(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] ecmd,
                     input bit eae, input bit epe);
    exp_t          e;
    logic [DW-1:0] c;
    bit            oae;
    bit            ope;
    e.inst = i; e.cmd = ecmd; e.ae = eae; e.pe = epe;
    sb.push_back(e);
    xfer(i, r, w, a, d, c, oae, ope);
    e = sb.pop_front();
    check($sformatf("command[%0d]@%0h", e.inst, a), 32'(c), 32'(e.cmd));
    check($sformatf("addr_err[%0d]@%0h", e.inst, a), 32'(oae), 32'(e.ae));
    check($sformatf("prot_err[%0d]@%0h", e.inst, a), 32'(ope), 32'(e.pe));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old;
    logic [DW-1:0] c;
    bit            oae;
    bit            ope;

    //          inst r  w  addr      data    cmd    ae pe
    vt[0]  = '{0, 0, 1, 13'h0100, 8'hA5, 8'h00, 0, 0};
    vt[1]  = '{0, 1, 0, 13'h0100, 8'h00, 8'hA5, 0, 0};
    vt[2]  = '{0, 1, 1, 13'h0010, 8'h99, 8'hA5, 1, 0};
    vt[3]  = '{0, 0, 1, 13'h0200, 8'h42, 8'hA5, 0, 0};
    vt[4]  = '{0, 0, 1, 13'h1FFE, 8'hC3, 8'hA5, 0, 0};
    vt[5]  = '{0, 1, 0, 13'h1FFE, 8'h00, 8'hC3, 0, 0};
    vt[6]  = '{1, 0, 1, 13'h1FFF, 8'h3C, 8'h00, 0, 0};
    vt[7]  = '{1, 1, 0, 13'h1FFF, 8'h00, 8'h3C, 0, 0};
    vt[8]  = '{1, 0, 1, 13'h0400, 8'h5C, 8'h3C, 0, 0};
    vt[9]  = '{2, 0, 1, 13'h0000, 8'h12, 8'h00, 0, 0};
    vt[10] = '{2, 0, 1, 13'h1000, 8'h77, 8'h00, 1, 0};
    vt[11] = '{2, 1, 0, 13'h0000, 8'h00, 8'h12, 0, 0};
    vt[12] = '{2, 1, 0, 13'h1000, 8'h00, 8'h00, 1, 0};
    vt[13] = '{2, 1, 0, 13'h0000, 8'h00, 8'h12, 0, 0};
    vt[14] = '{0, 1, 0, 13'h0200, 8'h00, 8'h42, 0, 0};

    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end

    // Reset values (asynchronous: checked before any clock edge).
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_command[%0d]", i), 32'(cmd[i]), 32'd0);
      check($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_addr_err[%0d]", i), 32'(ae[i]), 32'd0);
      check($sformatf("rst_prot_err[%0d]", i), 32'(pe[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      req(vt[v].inst, vt[v].r, vt[v].w, vt[v].a, vt[v].d, vt[v].ecmd, vt[v].eae, vt[v].epe);
    end

    // Zero-wait back-to-back: read held through ready, address switched
    // during the ready cycle; re-accepted in the first IDLE cycle.
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 13'h1FFF;
    @(posedge clk); #1;
    check("b2b_ready1", 32'(rdy[1]), 32'd1);
    check("b2b_cmd1", 32'(cmd[1]), 32'h3C);
    addr[1] = 13'h0400;
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(rdy[1]), 32'd0);
    check("b2b_idle_busy", 32'(bsy[1]), 32'd0);
    @(posedge clk); #1;
    check("b2b_ready2", 32'(rdy[1]), 32'd1);
    check("b2b_cmd2", 32'(cmd[1]), 32'h5C);
    rd[1] = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_ready", 32'(rdy[1]), 32'd0);
    check("b2b_end_busy", 32'(bsy[1]), 32'd0);

`ifdef MEM_PROTECT_EN
    xfer(0, 1'b1, 1'b0, 13'h00FF, 8'h00, old, oae, ope);
    req(0, 1'b0, 1'b1, 13'h00FF, 8'h11, old,   1'b0, 1'b1);
    req(0, 1'b1, 1'b0, 13'h00FF, 8'h00, old,   1'b0, 1'b0);
    req(0, 1'b0, 1'b1, 13'h0100, 8'h66, old,   1'b0, 1'b0);
    req(0, 1'b1, 1'b0, 13'h0100, 8'h00, 8'h66, 1'b0, 1'b0);
`else
    old = 8'h00;
`endif

    // Reset in the WAIT phase of a write of 0xFF to 0x0200.
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 13'h0200; wd[0] = 8'hFF;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    check("abort_busy_before", 32'(bsy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_async", 32'(bsy[0]), 32'd0);
    check("abort_cmd_async", 32'(cmd[0]), 32'd0);
    check("abort_ready_async", 32'(rdy[0]), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_no_ready_%0d", k), 32'(rdy[0]), 32'd0);
    end
    req(0, 1'b1, 1'b0, 13'h0200, 8'h00, 8'h42, 1'b0, 1'b0);
    req(1, 1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h3C, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    c = old;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
